// File: rtl/vector06_pkg.sv
// Shared types for the memory arbiter: requester ids, FSM states, idle read value.
package vector06_pkg;
  typedef enum logic [1:0] {OWN_LD, OWN_VID, OWN_CPU} owner_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam logic [7:0] DOUT_IDLE = 8'hFF;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, sram and status signals of the arbiter; slave = arbiter side, master = environment.
interface mem_arbiter_if #(parameter int AW = 25);
  logic          ld_req, ld_we, ld_ack;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_din;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_dout;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_dout;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;
  logic          mem_we, mem_rd, mem_ready;
  logic          timeout_err;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr, cpu_din,
           vid_req, vid_addr, mem_dout, mem_ready,
    output ld_ack, cpu_ack, cpu_dout, vid_ack, vid_dout, mem_addr, mem_din,
           mem_we, mem_rd, timeout_err
  );
  modport master (
    output ld_req, ld_we, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr, cpu_din,
           vid_req, vid_addr, mem_dout, mem_ready,
    input  ld_ack, cpu_ack, cpu_dout, vid_ack, vid_dout, mem_addr, mem_din,
           mem_we, mem_rd, timeout_err
  );
endinterface

// File: rtl/arb_prio.sv
// Combinational grant select: loader > video > CPU, CPU jumps video once it is starved.
module arb_prio
  import vector06_pkg::*;
(
  input  logic   i_ld_req,
  input  logic   i_vid_req,
  input  logic   i_cpu_req,
  input  logic   i_cpu_starved,
  output logic   o_grant,
  output owner_e o_owner
);
  always_comb begin
    o_grant = i_ld_req | i_vid_req | i_cpu_req;
    o_owner = OWN_LD;
    if (i_ld_req)
      o_owner = OWN_LD;
    else if (i_vid_req && !(i_cpu_req && i_cpu_starved))
      o_owner = OWN_VID;
    else if (i_cpu_req)
      o_owner = OWN_CPU;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Three-requester sram arbiter, one transaction in flight; grant->ack >= 4 cycles,
// losers simply hold their request level until granted.
module mem_arbiter
  import vector06_pkg::*;
#(
  parameter int AW         = 25,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk_sys,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  state_e         r_state, w_state_nxt;
  owner_e         r_owner, w_owner;
  logic [AW-1:0]  r_addr;
  logic [7:0]     r_din, r_cpu_dout, r_vid_dout;
  logic           r_we, r_tmo_err;
  logic [SCW-1:0] r_starve;
  logic [WCW-1:0] r_wait_cnt;
  logic           w_grant, w_cpu_starved, w_timeout, w_issue, w_done;
  logic [7:0]     w_rd_val;

  assign w_cpu_starved = (r_starve == SCW'(STARVE_MAX));
  assign w_timeout     = (r_wait_cnt == WCW'(TIMEOUT - 1));
  assign w_rd_val      = bus.mem_ready ? bus.mem_dout : DOUT_IDLE;

  arb_prio u_prio (
    .i_ld_req      (bus.ld_req),
    .i_vid_req     (bus.vid_req),
    .i_cpu_req     (bus.cpu_req),
    .i_cpu_starved (w_cpu_starved),
    .o_grant       (w_grant),
    .o_owner       (w_owner)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (w_grant) w_state_nxt = ISSUE;
      ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT:  if (bus.mem_ready || w_timeout) w_state_nxt = DONE;
      DONE:  begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_owner    <= OWN_LD;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_starve   <= '0;
      r_wait_cnt <= '0;
      r_tmo_err  <= 1'b0;
      r_cpu_dout <= DOUT_IDLE;
      r_vid_dout <= DOUT_IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.cpu_req) r_starve <= '0;
          if (w_grant) begin
            r_owner <= w_owner;
            case (w_owner)
              OWN_LD: begin
                r_addr <= bus.ld_addr;
                r_we   <= bus.ld_we;
                r_din  <= bus.ld_din;
              end
              OWN_VID: begin
                r_addr <= bus.vid_addr;
                r_we   <= 1'b0;
              end
              OWN_CPU: begin
                r_addr <= bus.cpu_addr;
                r_we   <= bus.cpu_we;
                r_din  <= bus.cpu_din;
              end
              default: ;
            endcase
            // starvation is only counted while the CPU is actually waiting
            if (w_owner == OWN_CPU)
              r_starve <= '0;
            else if (w_owner == OWN_VID && bus.cpu_req && !w_cpu_starved)
              r_starve <= r_starve + 1'b1;
          end
        end
        WAIT: begin
          if (bus.mem_ready || w_timeout) begin
            if (!r_we && r_owner == OWN_CPU) r_cpu_dout <= w_rd_val;
            if (!r_we && r_owner == OWN_VID) r_vid_dout <= w_rd_val;
            if (!bus.mem_ready) r_tmo_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_wait_cnt <= '0;
      endcase
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_din     = r_din;
  assign bus.mem_we      = w_issue & r_we;
  assign bus.mem_rd      = w_issue & ~r_we;
  assign bus.ld_ack      = w_done && (r_owner == OWN_LD);
  assign bus.vid_ack     = w_done && (r_owner == OWN_VID);
  assign bus.cpu_ack     = w_done && (r_owner == OWN_CPU);
  assign bus.cpu_dout    = r_cpu_dout;
  assign bus.vid_dout    = r_vid_dout;
  assign bus.timeout_err = r_tmo_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: bench plays requesters and sram, a transaction-level
// model predicts grant order, strobe/ack cycles and read data.
module tb_mem_arbiter;
  localparam int AW   = 25;
  localparam int SMAX = 4;
  localparam int TMO  = 255;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  mem_arbiter_if #(.AW(AW)) bus ();
  mem_arbiter #(.AW(AW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.slave)
  );

  int n_chk, n_fail, cyc;
  // requester index: 0 loader, 1 video, 2 cpu
  bit            rq[3], rq_hold[3];
  logic          rq_we[3];
  logic [AW-1:0] rq_addr[3];
  logic [7:0]    rq_din[3];
  bit rand_en, rst_req, rst_in_wait;
  int p_req, mem_dly;   // mem_dly: 0 random 1..4, -1 never ready, else fixed
  // model of the transaction in flight
  bit            m_busy, m_tmo, m_spur, m_zero, exp_err;
  int            m_own, m_strobe_at, m_ack_at, m_free_at, m_ready_at, starve;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din, m_rdata;
  logic [7:0]    exp_dout[3];
  int ack_log[$];
  int last_strb_cyc, last_ack_cyc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    rq[i] = 1'b1; rq_we[i] = (i == 1) ? 1'b0 : we; rq_addr[i] = a; rq_din[i] = d;
  endtask

  task automatic new_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom()), 8'($urandom()));
  endtask

  task automatic drive_reqs();
    bus.ld_req  = rq[0]; bus.ld_we  = rq_we[0]; bus.ld_addr  = rq_addr[0]; bus.ld_din  = rq_din[0];
    bus.vid_req = rq[1]; bus.vid_addr = rq_addr[1];
    bus.cpu_req = rq[2]; bus.cpu_we = rq_we[2]; bus.cpu_addr = rq_addr[2]; bus.cpu_din = rq_din[2];
  endtask

  task automatic step();
    logic [2:0] acks, exp_acks;
    logic [1:0] strb, exp_strb;
    bit inj;
    int d;
    @(negedge clk_sys);
    cyc++;
    if (reset) begin
      m_busy = 0; m_free_at = cyc; starve = 0; exp_err = 0; m_zero = 1;
      exp_dout[1] = 8'hFF; exp_dout[2] = 8'hFF;
    end
    exp_acks = '0; exp_strb = '0;
    if (m_busy && cyc == m_strobe_at) begin
      exp_strb = m_we ? 2'b10 : 2'b01;
      m_rdata  = 8'($urandom());
      m_spur   = rand_en && ($urandom_range(0, 3) == 0);
      if (mem_dly < 0) begin
        m_tmo = 1; m_ack_at = cyc + TMO + 1;
      end else begin
        d = (mem_dly == 0) ? int'($urandom_range(1, 4)) : mem_dly;
        m_tmo = 0; m_ready_at = cyc + d; m_ack_at = m_ready_at + 1;
      end
    end
    if (m_busy && cyc == m_ack_at) begin
      exp_acks[m_own] = 1'b1;
      if (!m_we && m_own != 0) exp_dout[m_own] = m_tmo ? 8'hFF : m_rdata;
      if (m_tmo) exp_err = 1;
    end
    acks = {bus.cpu_ack, bus.vid_ack, bus.ld_ack};
    strb = {bus.mem_we, bus.mem_rd};
    check_eq("acks", 32'(acks), 32'(exp_acks));
    check_eq("strobes", 32'(strb), 32'(exp_strb));
    if (m_busy && cyc >= m_strobe_at) begin
      check_eq("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (m_we) check_eq("mem_din", 32'(bus.mem_din), 32'(m_din));
    end
    if (m_zero) begin
      check_eq("mem_addr_rst", 32'(bus.mem_addr), 32'd0);
      check_eq("mem_din_rst", 32'(bus.mem_din), 32'd0);
    end
    check_eq("cpu_dout", 32'(bus.cpu_dout), 32'(exp_dout[2]));
    check_eq("vid_dout", 32'(bus.vid_dout), 32'(exp_dout[1]));
    check_eq("timeout_err", 32'(bus.timeout_err), 32'(exp_err));
    for (int i = 0; i < 3; i++) if (acks[i]) ack_log.push_back(i);
    if (strb != 0) last_strb_cyc = cyc;
    if (acks != 0) last_ack_cyc = cyc;
    // new requests are raised before acks drop, so a finished requester rests one cycle
    if (rand_en)
      for (int i = 0; i < 3; i++)
        if (!rq[i] && $urandom_range(0, 99) < p_req) new_req(i);
    if (m_busy && cyc == m_ack_at) begin
      m_busy = 0; m_free_at = cyc + 1;
      if (rq_hold[m_own]) new_req(m_own);
      else rq[m_own] = 0;
    end
    bus.mem_ready = (cyc == m_ready_at) || (m_spur && m_busy && cyc == m_strobe_at);
    bus.mem_dout  = (cyc == m_ready_at) ? m_rdata : 8'($urandom());
    inj = rst_in_wait && m_busy && (cyc == m_strobe_at + 1);
    if (inj) rst_in_wait = 0;
    if (rst_req || inj)
      for (int i = 0; i < 3; i++) begin rq[i] = 0; rq_hold[i] = 0; end
    reset = rst_req || inj;
    drive_reqs();
    if (!reset && !m_busy && cyc >= m_free_at) begin
      if (!rq[2]) starve = 0;
      if (rq[0] || rq[1] || rq[2]) begin
        if (rq[0]) m_own = 0;
        else if (rq[1] && !(rq[2] && starve == SMAX)) m_own = 1;
        else m_own = 2;
        if (m_own == 2) starve = 0;
        else if (m_own == 1 && rq[2] && starve < SMAX) starve++;
        m_busy = 1; m_zero = 0; m_strobe_at = cyc + 1;
        m_we = rq_we[m_own]; m_addr = rq_addr[m_own]; m_din = rq_din[m_own];
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; rst_req = 1; rst_in_wait = 0; rand_en = 0; p_req = 30; mem_dly = 0;
    for (int i = 0; i < 3; i++) begin
      rq[i] = 0; rq_hold[i] = 0; rq_we[i] = 0; rq_addr[i] = '0; rq_din[i] = '0; exp_dout[i] = 8'hFF;
    end
    m_busy = 0; m_zero = 1; exp_err = 0; starve = 0; m_own = 0; m_we = 0; m_addr = '0; m_din = '0;
    m_tmo = 0; m_spur = 0; m_rdata = '0; m_free_at = 0;
    m_strobe_at = -100; m_ack_at = -100; m_ready_at = -100; last_strb_cyc = 0; last_ack_cyc = 0;
    bus.mem_ready = 1'b0; bus.mem_dout = 8'h00;
    drive_reqs();
    run(3);
    rst_req = 0;
    run(3);

    // single CPU read, sram ready 3 cycles after the strobe
    mem_dly = 3; set_req(2, 1'b0, 25'h00100, 8'h00); run(12);
    check_eq("rd_latency", 32'(last_ack_cyc - last_strb_cyc), 32'd4);

    // CPU write at the top of a 17-bit page: read data must not move
    mem_dly = 2; set_req(2, 1'b1, 25'h1FFFF, 8'hA5); run(10);

    // all three requesters in the same cycle
    mem_dly = 0; ack_log.delete();
    new_req(0); new_req(1); new_req(2); run(30);
    check_eq("simul_count", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() == 3)
      for (int i = 0; i < 3; i++) check_eq("simul_order", 32'(ack_log[i]), 32'(i));

    // video hogging the bus while the CPU waits
    mem_dly = 1; ack_log.delete();
    rq_hold[1] = 1; rq_hold[2] = 1; new_req(1); new_req(2); run(45);
    rq_hold[1] = 0; rq_hold[2] = 0; run(20);
    check_eq("starve_count", 32'(ack_log.size() >= 10), 32'd1);
    if (ack_log.size() >= 10)
      for (int i = 0; i < 10; i++) check_eq("starve_order", 32'(ack_log[i]), (i % 5 == 4) ? 32'd2 : 32'd1);

    // sram never answers: forced completion and sticky error
    mem_dly = -1; set_req(2, 1'b0, AW'($urandom()), 8'h00); run(TMO + 12);

    // random traffic with random sram latency and ISSUE-cycle ready glitches
    mem_dly = 0; rand_en = 1; run(1500);
    rand_en = 0; run(40);

    // reset while waiting for sram, ready arriving the following cycle
    mem_dly = 2; rst_in_wait = 1; set_req(2, 1'b0, AW'($urandom()), 8'h00); run(10);

    // a little more traffic after the mid-transaction reset
    rand_en = 1; run(200);
    rand_en = 0; run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 25: memory address width.
REQ-002 Parameter STARVE_MAX, default 4: consecutive video grants allowed while a CPU request is pending.
REQ-003 Parameter TIMEOUT, default 255: WAIT-state cycles before forced completion.
REQ-004 clk_sys  in  1  system clock (96 MHz); all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ld_req, ld_we  in  1,1  loader request (level) and write flag.
REQ-007 ld_addr, ld_din  in  AW,8  loader address and write data.
REQ-008 ld_ack  out  1  loader completion pulse.
REQ-009 cpu_req, cpu_we  in  1,1  CPU request (level) and write flag.
REQ-010 cpu_addr, cpu_din  in  AW,8  CPU address (page bits included) and write data.
REQ-011 cpu_dout, cpu_ack  out  8,1  CPU read data and completion pulse.
REQ-012 vid_req, vid_addr  in  1,AW  video fetch request (read-only) and address.
REQ-013 vid_dout, vid_ack  out  8,1  video read data and completion pulse.
REQ-014 mem_addr, mem_din  out  AW,8  address and write data to sram port.
REQ-015 mem_we, mem_rd  out  1,1  one-cycle write/read strobes to sram.
REQ-016 mem_dout, mem_ready  in  8,1  sram read data and completion.
REQ-017 timeout_err  out  1  sticky error flag.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-019 IDLE: grant on first cycle any req high; priority loader > video > CPU, except CPU wins over video when starve_cnt == STARVE_MAX.
REQ-020 starve_cnt: +1 per video grant while cpu_req high, saturating at STARVE_MAX; cleared on CPU grant or when cpu_req low in IDLE.
REQ-021 On grant, latch owner, addr, we, din; next state ISSUE.
REQ-022 ISSUE (one cycle): mem_addr/mem_din driven from latches; mem_we = latched we, mem_rd = ~latched we; next WAIT.
REQ-023 mem_addr/mem_din hold latched values through WAIT and DONE; strobes low outside ISSUE.
REQ-024 WAIT: on mem_ready high, capture mem_dout into owner's dout register, go DONE; mem_ready in ISSUE cycle ignored.
REQ-025 WAIT timeout: wait counter reaching TIMEOUT forces DONE with dout = 8'hFF, sets timeout_err.
REQ-026 DONE (one cycle): owner's ack high exactly this cycle, dout valid from this cycle until that owner's next ack; next IDLE.
REQ-027 Latency: grant cycle N, strobe N+1, mem_ready at cycle k>N+1 gives ack at k+1; minimum 4 cycles req-to-ack.
REQ-028 Request withdrawn mid-transaction: transaction completes, ack still pulsed.
REQ-029 Requester must drop req on cycle after ack; a req still high in IDLE after DONE is a new request.
REQ-030 Simultaneous requests: only the winner is served; losers hold, no ack, no data change.
REQ-031 Writes never modify any dout register.
REQ-032 Video request with vid_we absent: always read.

Reset
REQ-033 Reset, any cycle including mid-transaction: state IDLE, strobes 0, all acks 0, starve_cnt 0, wait counter 0, timeout_err 0, cpu_dout/vid_dout 8'hFF, mem_addr/mem_din 0; in-flight transaction abandoned without ack.
REQ-034 Reset takes priority over every other event in the same cycle.

Structure
REQ-035 Shared package vector06_pkg holds owner enum (OWN_LD, OWN_VID, OWN_CPU), FSM state enum and DOUT_IDLE = 8'hFF.
REQ-036 Single sub-module arb_prio (combinational priority/starvation grant select); rest flat.

Verification
REQ-037 Single CPU read addr 0x00100, mem_ready 3 cycles after strobe -> mem_rd one pulse, cpu_ack at strobe+4, cpu_dout = mem_dout.
REQ-038 ld_req, vid_req, cpu_req all high same cycle -> order loader, video, CPU; one ack each, no overlap.
REQ-039 vid_req continuously high, cpu_req high -> CPU granted after exactly 4 video grants, then counter restarts.
REQ-040 mem_ready never asserted -> ack after TIMEOUT WAIT cycles, dout 8'hFF, timeout_err stays 1 until reset.
REQ-041 reset during WAIT, mem_ready next cycle -> no ack, state IDLE, outputs at reset values.
REQ-042 CPU write 0xA5 to 0x1FFFF -> mem_we one pulse, mem_din 0xA5, cpu_dout unchanged.
